// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Pipeline hazard unit for the 5-stage core. It detects load-use
//            hazards, or applies a full interlock when forwarding is disabled.
//            It generates EX forwarding selects and flushes on taken branches.
//            A hold FSM covers multi-cycle mul/div, and the unit keeps stall
//            and flush performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int REG_W  = 5,
    parameter int FWD_EN = 1,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] ex_rs1,
    input  logic [REG_W-1:0] ex_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic             ex_muldiv,
    input  logic             ex_branch_taken,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_regwrite,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_regwrite,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    // The down-counter only has to hold MD_LAT-2 at most.
    localparam int              c_CNT_W    = (MD_LAT > 2) ? $clog2(MD_LAT - 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = (MD_LAT >= 2) ? c_CNT_W'(MD_LAT - 2) : '0;
    localparam logic            c_MD_MULTI = (MD_LAT >= 2);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_stateNext;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cntNext;
    logic               w_mdHold;
    logic               w_dataHazard;
    logic [1:0]         w_fwdA;
    logic [1:0]         w_fwdB;
    logic [CNT_W-1:0]   r_stallCycles;
    logic [CNT_W-1:0]   r_flushCount;

    // A source depends on a writer only if it is read, is not x0, and the writer writes it.
    function automatic logic regMatch(input logic used, input logic [REG_W-1:0] src,
                                      input logic [REG_W-1:0] wr, input logic we);
        return used && (src != '0) && (src == wr) && we;
    endfunction

    // The write-through register file means a WB writer never creates an ID hazard.
    generate
        if (FWD_EN != 0) begin : g_fwd
            assign w_dataHazard = ex_memread &&
                                  (regMatch(id_rs1_used, id_rs1, ex_rd, ex_regwrite) ||
                                   regMatch(id_rs2_used, id_rs2, ex_rd, ex_regwrite));
            // MEM is the younger result, so it takes priority over WB.
            assign w_fwdA = regMatch(1'b1, ex_rs1, mem_rd, mem_regwrite) ? 2'b10 :
                            regMatch(1'b1, ex_rs1, wb_rd,  wb_regwrite)  ? 2'b01 : 2'b00;
            assign w_fwdB = regMatch(1'b1, ex_rs2, mem_rd, mem_regwrite) ? 2'b10 :
                            regMatch(1'b1, ex_rs2, wb_rd,  wb_regwrite)  ? 2'b01 : 2'b00;
        end else begin : g_interlock
            assign w_dataHazard = regMatch(id_rs1_used, id_rs1, ex_rd,  ex_regwrite)  ||
                                  regMatch(id_rs2_used, id_rs2, ex_rd,  ex_regwrite)  ||
                                  regMatch(id_rs1_used, id_rs1, mem_rd, mem_regwrite) ||
                                  regMatch(id_rs2_used, id_rs2, mem_rd, mem_regwrite);
            assign w_fwdA = 2'b00;
            assign w_fwdB = 2'b00;
        end
    endgenerate

    // Mul/div FSM state and down-counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    // Next state: enter BUSY on a multi-cycle op and count down the remaining holds.
    // On the release cycle the FSM ignores ex_muldiv, because that op is the one leaving EX.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        case (r_state)
            c_IDLE: begin
                if (ex_muldiv && c_MD_MULTI) begin
                    w_stateNext = c_BUSY;
                    w_cntNext   = c_CNT_LOAD;
                end
            end
            c_BUSY: begin
                if (r_cnt != '0) begin
                    w_cntNext = r_cnt - c_CNT_W'(1);
                end else begin
                    w_stateNext = c_IDLE;
                end
            end
            default: begin
                w_stateNext = c_IDLE;
                w_cntNext   = '0;
            end
        endcase
    end

    // FSM output: hold the pipeline on every cycle of the op except the release cycle.
    always_comb begin
        w_mdHold = 1'b0;
        case (r_state)
            c_IDLE:  w_mdHold = ex_muldiv && c_MD_MULTI;
            c_BUSY:  w_mdHold = (r_cnt != '0);
            default: w_mdHold = 1'b0;
        endcase
    end

    // Pipeline control by priority: mul/div hold, then taken branch, then data hazard.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (rst) begin
            pc_stall = 1'b0;
        end else if (w_mdHold) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_flush = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (w_dataHazard) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
        end
    end

    assign fwd_a   = rst ? 2'b00 : w_fwdA;
    assign fwd_b   = rst ? 2'b00 : w_fwdB;
    assign md_busy = !rst && (r_state == c_BUSY);

    // Performance counters, free-running and wrapping at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCycles <= '0;
            r_flushCount  <= '0;
        end else begin
            if (pc_stall)   r_stallCycles <= r_stallCycles + CNT_W'(1);
            if (ifid_flush) r_flushCount  <= r_flushCount + CNT_W'(1);
        end
    end

    assign stall_cycles = r_stallCycles;
    assign flush_count  = r_flushCount;

endmodule
`default_nettype wire
